// File: rtl/led_array_main.sv
// LED matrix column scanner with an SPI-loaded 32-column frame buffer.
// Optional one-hot sink-select output o_LED_SINK is built when LED_ARRAY_SINK_EN is defined.
module led_array_main #(
  parameter int P_COLS     = 32,
  parameter int P_SCAN_DIV = 1000
) (
  input  logic        i_CLK,
  input  logic        i_RESET,
  input  logic        i_SPI_CLK,
  input  logic        i_SPI_ENA_n,
  input  logic        i_SPI_DATA,
  input  logic        i_ENA_p,
  output logic [31:0] o_LED,
  output logic        o_TOGGLE_SYNC,
  output logic        o_HEAD_FLAG
`ifdef LED_ARRAY_SINK_EN
  ,
  output logic [31:0] o_LED_SINK
`endif
);

  localparam int              PW       = (P_SCAN_DIV > 1) ? $clog2(P_SCAN_DIV) : 1;
  localparam logic [4:0]      LAST_COL = 5'(P_COLS - 1);
  localparam logic [5:0]      NCOLS    = 6'(P_COLS);
  localparam logic [PW-1:0]   LAST_PRE = PW'(P_SCAN_DIV - 1);

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'd33) ? v : v + 6'd1;
  endfunction

  logic [2:0]  sclk_sync;
  logic [2:0]  sena_sync;
  logic [1:0]  sdat_sync;
  logic        sclk_rise;
  logic        sena_fall;
  logic        sena_rise;
  logic        sena_low;
  logic        sdat;

  logic [31:0] shreg;
  logic [5:0]  bit_cnt;
  logic        wr_vld_p0;
  logic [31:0] wr_word_p0;
  logic [2:0]  wr_op;
  logic [4:0]  wr_addr;
  logic        addr_ok;

  logic [31:0] frame_mem [32];
  logic [4:0]  col;
  logic [PW-1:0] presc;
  logic        slot_end_p0;

  // Stage: SPI line synchronizers; reset to idle levels so no false edge is seen.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      sclk_sync <= 3'b111;
      sena_sync <= 3'b111;
      sdat_sync <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[1:0], i_SPI_CLK};
      sena_sync <= {sena_sync[1:0], i_SPI_ENA_n};
      sdat_sync <= {sdat_sync[0], i_SPI_DATA};
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sena_fall = ~sena_sync[1] & sena_sync[2];
  assign sena_rise = sena_sync[1] & ~sena_sync[2];
  assign sena_low  = ~sena_sync[1];
  assign sdat      = sdat_sync[1];

  // Stage p0: shift register, bit count and frame commit.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      wr_vld_p0 <= 1'b0;
    end else begin
      wr_vld_p0 <= sena_rise && (bit_cnt == 6'd32);
      if (sena_fall) begin
        bit_cnt <= '0;
      end else if (sclk_rise && sena_low) begin
        shreg   <= {shreg[30:0], sdat};
        bit_cnt <= sat_inc(bit_cnt);
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    wr_word_p0 <= shreg;
  end

  assign wr_op   = wr_word_p0[31:29];
  assign wr_addr = wr_word_p0[28:24];
  assign addr_ok = {1'b0, wr_addr} < NCOLS;

  // Stage p1: frame buffer write.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      for (int i = 0; i < 32; i++) frame_mem[i] <= '0;
    end else if (wr_vld_p0 && addr_ok) begin
      case (wr_op)
        3'b000:  frame_mem[wr_addr][23:0]  <= wr_word_p0[23:0];
        3'b001:  frame_mem[wr_addr][31:24] <= wr_word_p0[7:0];
        default: ;
      endcase
    end
  end

  // Stage: column scan; outputs lag col by one clock, so the toggle flip is delayed to match.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      col           <= '0;
      presc         <= '0;
      slot_end_p0   <= 1'b0;
      o_LED         <= '0;
      o_HEAD_FLAG   <= 1'b0;
      o_TOGGLE_SYNC <= 1'b0;
`ifdef LED_ARRAY_SINK_EN
      o_LED_SINK    <= '0;
`endif
    end else if (!i_ENA_p) begin
      col         <= '0;
      presc       <= '0;
      slot_end_p0 <= 1'b0;
      o_LED       <= '0;
      o_HEAD_FLAG <= 1'b0;
`ifdef LED_ARRAY_SINK_EN
      o_LED_SINK  <= '0;
`endif
    end else begin
      o_LED         <= frame_mem[col];
      o_HEAD_FLAG   <= (col == 5'd0);
      o_TOGGLE_SYNC <= o_TOGGLE_SYNC ^ slot_end_p0;
`ifdef LED_ARRAY_SINK_EN
      o_LED_SINK    <= 32'd1 << col;
`endif
      slot_end_p0   <= (presc == LAST_PRE);
      if (presc == LAST_PRE) begin
        presc <= '0;
        col   <= (col == LAST_COL) ? 5'd0 : col + 5'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_array_main.sv
// Bench for led_array_main at P_COLS=4, P_SCAN_DIV=4: per-cycle model compare plus directed literals.
module tb_led_array_main;
  localparam int COLS = 4;
  localparam int DIV  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_clk = 1'b1;
  logic spi_ena_n = 1'b1;
  logic spi_data = 1'b0;
  logic ena = 1'b0;
  logic [31:0] led;
  logic tog;
  logic head;
`ifdef LED_ARRAY_SINK_EN
  logic [31:0] sink;
`endif

  led_array_main #(.P_COLS(COLS), .P_SCAN_DIV(DIV)) dut (
    .i_CLK(clk),
    .i_RESET(rst),
    .i_SPI_CLK(spi_clk),
    .i_SPI_ENA_n(spi_ena_n),
    .i_SPI_DATA(spi_data),
    .i_ENA_p(ena),
    .o_LED(led),
    .o_TOGGLE_SYNC(tog),
    .o_HEAD_FLAG(head)
`ifdef LED_ARRAY_SINK_EN
    ,
    .o_LED_SINK(sink)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] mem_m [COLS];
  int n_en = 0;
  logic tog_m = 1'b0;
  logic hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: n_en counts enabled clocks since enable; the slot shown follows from it arithmetically.
  always @(negedge clk) begin
    int col_m;
    logic [31:0] led_e;
    logic head_e;
    if (rst) begin
      n_en = 0;
      tog_m = 1'b0;
      for (int i = 0; i < COLS; i++) mem_m[i] = '0;
    end else if (ena) begin
      n_en++;
      if (n_en > 1 && (n_en - 1) % DIV == 0) tog_m = ~tog_m;
    end else begin
      n_en = 0;
    end
    if (n_en == 0) begin
      col_m = 0; led_e = '0; head_e = 1'b0;
    end else begin
      col_m = ((n_en - 1) / DIV) % COLS;
      led_e = mem_m[col_m];
      head_e = (col_m == 0);
    end
    if (!hold) check("led", led, led_e);
    check("head", 32'(head), 32'(head_e));
    check("toggle", 32'(tog), 32'(tog_m));
`ifdef LED_ARRAY_SINK_EN
    check("sink", sink, (n_en == 0) ? 32'd0 : (32'd1 << col_m));
`endif
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
    #1;
  endtask

  task automatic apply(input logic [31:0] w);
    int a;
    a = int'(w[28:24]);
    if (a < COLS) begin
      if (w[31:29] == 3'b000) mem_m[a][23:0] = w[23:0];
      else if (w[31:29] == 3'b001) mem_m[a][31:24] = w[7:0];
    end
  endtask

  task automatic spi_bits(input logic [63:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) begin
      spi_data = v[i];
      spi_clk = 1'b0;
      tick(4);
      spi_clk = 1'b1;
      tick(4);
    end
  endtask

  task automatic spi_frame(input logic [63:0] v, input int nb);
    hold = 1'b1;
    spi_ena_n = 1'b0;
    tick(4);
    spi_bits(v, nb);
    spi_ena_n = 1'b1;
    tick(10);
    if (nb == 32) apply(v[31:0]);
    hold = 1'b0;
  endtask

`ifdef LED_ARRAY_SINK_EN
  logic [31:0] walk [5];
`endif

  initial begin
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_led", led, 32'd0);
    check("rst_tog", 32'(tog), 32'd0);
    check("rst_head", 32'(head), 32'd0);

    ena = 1'b1;
    tick(20);
    ena = 1'b0;
    tick(2);

    spi_frame(64'h03000100, 32);
    ena = 1'b1;
    tick(1);
    check("t2_head_col0", 32'(head), 32'd1);
    check("t2_led_col0", led, 32'd0);
    tick(12);
    check("t2_led_col3", led, 32'h00000100);
    check("t2_head_col3", 32'(head), 32'd0);
    check("t2_tog_col3", 32'(tog), 32'd1);
    tick(8);

    spi_frame(64'h230000A5, 32);
    ena = 1'b0;
    tick(1);
    check("t3_off_led", led, 32'd0);
    ena = 1'b1;
    tick(13);
    check("t3_led_col3", led, 32'hA5000100);

    ena = 1'b0;
    tick(1);
    spi_frame(64'h00ABCDEF, 31);
    spi_frame(64'h1_00ABCDEF, 33);
    spi_frame(64'hE0ABCDEF, 32);
    spi_frame(64'h1FABCDEF, 32);
    ena = 1'b1;
    tick(1);
    check("t4_col0_unchanged", led, 32'd0);
    ena = 1'b0;
    tick(1);
    spi_frame(64'h00ABCDEF, 32);
    spi_frame(64'h21000012, 32);
    ena = 1'b1;
    tick(1);
    check("t4_col0_written", led, 32'h00ABCDEF);
    tick(4);
    check("t4_col1_hi", led, 32'h12000000);

    tick(1);
    ena = 1'b0;
    tick(1);
    check("t5_off_led", led, 32'd0);
    check("t5_off_head", 32'(head), 32'd0);
    ena = 1'b1;
    tick(1);
    check("t5_restart_head", 32'(head), 32'd1);
    check("t5_restart_led", led, 32'h00ABCDEF);
    tick(3);
    check("t5_head_4th", 32'(head), 32'd1);
    tick(1);
    check("t5_head_5th", 32'(head), 32'd0);

    ena = 1'b0;
    hold = 1'b1;
    spi_ena_n = 1'b0;
    tick(4);
    spi_bits(64'h0300, 16);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    spi_bits(64'h1234, 16);
    spi_ena_n = 1'b1;
    tick(10);
    hold = 1'b0;
    ena = 1'b1;
    tick(13);
    check("rst_mid_col3", led, 32'd0);

`ifdef LED_ARRAY_SINK_EN
    walk[0] = 32'h1; walk[1] = 32'h2; walk[2] = 32'h4; walk[3] = 32'h8; walk[4] = 32'h1;
    ena = 1'b0;
    tick(1);
    check("t6_sink_off", sink, 32'd0);
    ena = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick((k == 0) ? 1 : 4);
      check("t6_sink_walk", sink, walk[k]);
    end
`endif

    ena = 1'b0;
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
